// File: rtl/wb_pkg.sv
// Wishbone bus encodings shared by the SRAM reader and the result path.
package wb_pkg;

  localparam logic [2:0] CTI_INCREMENTING_BURST = 3'b010;
  localparam logic [2:0] CTI_END_OF_BURST       = 3'b111;
  localparam logic [1:0] BTE_LINEAR             = 2'b00;

endpackage : wb_pkg

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with occupancy count and flush.
// The head byte is presented combinationally from storage.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          do_push_s;
  logic          do_pop_s;
  logic [CW-1:0] cnt_next_s;

  assign rdata = mem_r[rd_ptr_r];
  assign count = cnt_r;
  assign empty = (cnt_r == CNT_ZERO);
  assign full  = (cnt_r == CNT_FULL);

  // Qualify push/pop against occupancy and work out the next count.
  always_comb begin
    do_pop_s   = pop && !empty;
    do_push_s  = push && (!full || do_pop_s);
    cnt_next_s = cnt_r + (do_push_s ? CNT_ONE : CNT_ZERO) - (do_pop_s ? CNT_ONE : CNT_ZERO);
  end

  // Storage, pointers and count; flush empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= CNT_ZERO;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      cnt_r <= cnt_next_s;
    end
  end

endmodule : byte_fifo

// File: rtl/sram_burst_reader.sv
// Wishbone burst reader: fetches LEN bytes from external SRAM with linear
// incrementing bursts and streams them out through a small byte FIFO.
// A burst is ended when the FIFO fills and restarted at the next unfetched
// address once the FIFO has drained to half; the slave is expected to drop
// any partially shifted byte when cyc/stb fall.
module sram_burst_reader
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [23:0]          addr_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 wb_cyc_o,
  output logic                 wb_stb_o,
  output logic [23:0]          wb_adr_o,
  output logic                 wb_we_o,
  output logic [7:0]           wb_dat_o,
  output logic [2:0]           wb_cti_o,
  output logic [1:0]           wb_bte_o,
  input  logic                 wb_ack_i,
  input  logic [7:0]           wb_dat_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]        CNT_ZERO = CW'(0);
  localparam logic [CW-1:0]        CNT_FULL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]        CNT_HALF = CW'(FIFO_DEPTH / 2);
  localparam logic [LEN_WIDTH-1:0] REM_ONE  = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] REM_ZERO = LEN_WIDTH'(0);

  state_t               state_r;
  state_t               state_next_s;
  logic [23:0]          adr_r;
  logic [23:0]          adr_next_s;
  logic [LEN_WIDTH-1:0] rem_r;
  logic [LEN_WIDTH-1:0] rem_next_s;
  logic                 busy_r;
  logic                 done_r;
  logic                 done_next_s;
  logic                 cyc_r;

  logic                 push_s;
  logic                 pop_s;
  logic                 flush_s;
  logic [CW-1:0]        cnt_post_s;
  logic [CW-1:0]        fifo_count_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .flush (flush_s),
    .push  (push_s),
    .wdata (wb_dat_i),
    .pop   (pop_s),
    .rdata (data_o),
    .count (fifo_count_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  assign valid_o  = !fifo_empty_s;
  assign busy_o   = busy_r;
  assign done_o   = done_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign wb_adr_o = adr_r;
  assign wb_we_o  = 1'b0;
  assign wb_dat_o = 8'h00;
  assign wb_cti_o = CTI_INCREMENTING_BURST;
  assign wb_bte_o = BTE_LINEAR;

  // Next-state logic: FIFO handshakes, burst pacing, abort and completion.
  always_comb begin
    state_next_s = state_r;
    adr_next_s   = adr_r;
    rem_next_s   = rem_r;
    done_next_s  = 1'b0;
    flush_s      = abort_i && (state_r != ST_IDLE);
    pop_s        = valid_o && ready_i;
    push_s       = (state_r == ST_FETCH) && wb_ack_i && !abort_i && (!fifo_full_s || pop_s);
    cnt_post_s   = fifo_count_s + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);

    if (flush_s) begin
      state_next_s = ST_IDLE;
      rem_next_s   = REM_ZERO;
      done_next_s  = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i && (len_i != REM_ZERO)) begin
            adr_next_s   = addr_i;
            rem_next_s   = len_i;
            state_next_s = ST_FETCH;
          end else if (start_i) begin
            done_next_s  = 1'b1;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_FETCH: begin
          if (push_s) begin
            rem_next_s = rem_r - REM_ONE;
            adr_next_s = adr_r + 24'd1;
            if (rem_next_s == REM_ZERO) begin
              state_next_s = ST_DRAIN;
            end else if (cnt_post_s == CNT_FULL) begin
              state_next_s = ST_PAUSE;
            end else begin
              state_next_s = ST_FETCH;
            end
          end else begin
            state_next_s = ST_FETCH;
          end
        end
        ST_PAUSE: begin
          if (cnt_post_s <= CNT_HALF) begin
            state_next_s = ST_FETCH;
          end else begin
            state_next_s = ST_PAUSE;
          end
        end
        ST_DRAIN: begin
          if (cnt_post_s == CNT_ZERO) begin
            state_next_s = ST_IDLE;
            done_next_s  = 1'b1;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default: begin
          state_next_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register and registered bus/status outputs derived from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      adr_r   <= 24'h000000;
      rem_r   <= REM_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cyc_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      adr_r   <= adr_next_s;
      rem_r   <= rem_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= done_next_s;
      cyc_r   <= (state_next_s == ST_FETCH);
    end
  end

endmodule : sram_burst_reader

// File: tb/tb_sram_burst_reader.sv
// Self-checking bench for sram_burst_reader: a randomly acking SRAM slave,
// a consumer with selectable backpressure, and a reference model that expects
// byte i of a transfer to be SRAM[addr+i] fetched from address addr+i.
module tb_sram_burst_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [23:0] addr_i;
  logic [15:0] len_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [23:0] wb_adr_o;
  logic        wb_we_o;
  logic [7:0]  wb_dat_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i;
  logic [7:0]  wb_dat_i;

  int tests_run    = 0;
  int tests_failed = 0;

  sram_burst_reader #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .addr_i(addr_i), .len_i(len_i),
    .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o), .data_o(data_o), .valid_o(valid_o),
    .ready_i(ready_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o), .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  // SRAM content model
  function automatic logic [7:0] sram(input logic [23:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'hA5;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Full transfer with random slave acks; rmode 0: ready=1, 1: random, 2: ready=0 until first cyc drop
  task automatic run_xfer(input logic [23:0] a, input int n, input int rmode,
                          input bit hold_start, input string name);
    logic [7:0]  got[$];
    logic [23:0] adrs[$];
    logic [23:0] e_adr;
    int  cyc_cnt = 0, first_drop = -1, pause_cycles = 0, bad = 0;
    bit  done_seen = 0, pop_prev = 0, cyc_prev = 0, restarted = 0;
    bit  busy_bad = 0, const_bad = 0, cyc_late = 0;
    start_i = 1'b1; addr_i = a; len_i = 16'(n);
    @(negedge clk);
    if (hold_start) begin
      addr_i = a ^ 24'h800000; len_i = 16'd7;
    end else begin
      start_i = 1'b0;
    end
    while (!done_seen && cyc_cnt < 4000) begin
      if (done_o) begin
        done_seen = 1;
      end else begin
        if (busy_o !== 1'b1) busy_bad = 1;
        if (wb_stb_o !== wb_cyc_o || wb_we_o !== 1'b0 || wb_dat_o !== 8'h00 ||
            wb_cti_o !== 3'b010 || wb_bte_o !== 2'b00) const_bad = 1;
        if (wb_cyc_o && adrs.size() >= n) cyc_late = 1;
        if (cyc_prev && !wb_cyc_o && first_drop < 0) first_drop = adrs.size();
        if (first_drop >= 0 && !restarted) begin
          if (wb_cyc_o) restarted = 1; else pause_cycles++;
        end
        cyc_prev = wb_cyc_o;
        case (rmode)
          0:       ready_i = 1'b1;
          1:       ready_i = ($urandom_range(0, 2) != 0);
          default: ready_i = (first_drop >= 0);
        endcase
        wb_ack_i = wb_cyc_o && ($urandom_range(0, 3) != 0);
        wb_dat_i = wb_ack_i ? sram(wb_adr_o) : 8'($urandom);
        if (wb_ack_i) adrs.push_back(wb_adr_o);
        pop_prev = valid_o && ready_i;
        if (pop_prev) got.push_back(data_o);
        @(negedge clk);
        cyc_cnt++;
      end
    end
    start_i = 1'b0; wb_ack_i = 1'b0; ready_i = 1'b0;

    tests_run++;
    if (!done_seen) begin
      tests_failed++; $display("FAIL %s timeout: done_o=0 after %0d cycles, required done_o=1", name, cyc_cnt);
    end
    tests_run++;
    if (!(pop_prev && got.size() == n)) begin
      tests_failed++; $display("FAIL %s done_timing: pops=%0d last_cycle_pop=%0d, required pops=%0d last_cycle_pop=1", name, got.size(), pop_prev, n);
    end
    for (int i = 0; i < n && i < got.size(); i++) begin
      e_adr = a + 24'(i);
      if (got[i] !== sram(e_adr)) bad++;
    end
    tests_run++;
    if (got.size() != n || bad != 0) begin
      tests_failed++; $display("FAIL %s stream: %0d bytes with %0d wrong, required %0d bytes all matching SRAM", name, got.size(), bad, n);
    end
    bad = 0;
    for (int i = 0; i < adrs.size(); i++) begin
      e_adr = a + 24'(i);
      if (adrs[i] !== e_adr) bad++;
    end
    tests_run++;
    if (adrs.size() != n || bad != 0) begin
      tests_failed++; $display("FAIL %s addresses: %0d acks with %0d out of sequence, required %0d acks from %h upward", name, adrs.size(), bad, n, a);
    end
    tests_run++;
    if (busy_bad || const_bad || cyc_late) begin
      tests_failed++; $display("FAIL %s bus_status: busy_gap=%0d const_err=%0d cyc_after_last=%0d, required all 0", name, busy_bad, const_bad, cyc_late);
    end
    if (rmode == 2 && n > DEPTH) begin
      tests_run++;
      if (first_drop != DEPTH || pause_cycles != (DEPTH - DEPTH / 2)) begin
        tests_failed++; $display("FAIL %s pause: acks_before_drop=%0d pause_cycles=%0d, required %0d and %0d", name, first_drop, pause_cycles, DEPTH, DEPTH - DEPTH / 2);
      end
    end
    tests_run++;
    if (busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      tests_failed++; $display("FAIL %s done_state: busy=%b cyc=%b, required 0 0", name, busy_o, wb_cyc_o);
    end
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL %s after_done: done=%b busy=%b, required 0 0", name, done_o, busy_o);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; addr_i = 24'h0; len_i = 16'd0; abort_i = 1'b0;
    ready_i = 1'b0; wb_ack_i = 1'b0; wb_dat_i = 8'h00;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || valid_o !== 1'b0 || wb_cyc_o !== 1'b0 ||
        wb_stb_o !== 1'b0 || wb_adr_o !== 24'h0 || wb_we_o !== 1'b0 || wb_dat_o !== 8'h00 ||
        wb_cti_o !== 3'b010 || wb_bte_o !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b valid=%b cyc=%b stb=%b adr=%h we=%b cti=%b bte=%b, required 0 0 0 0 0 000000 0 010 00",
               busy_o, done_o, valid_o, wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_cti_o, wb_bte_o);
    end
    rst_ni = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    bit cyc_seen = 0;
    start_i = 1'b1; addr_i = 24'h123456; len_i = 16'd0;
    @(negedge clk);
    start_i = 1'b0;
    tests_run++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len: done=%b busy=%b cyc=%b, required 1 0 0", done_o, busy_o, wb_cyc_o);
    end
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b0) begin
      tests_failed++; $display("FAIL zero_len_pulse: done=%b one cycle later, required 0", done_o);
    end
    repeat (4) begin
      if (wb_cyc_o || busy_o) cyc_seen = 1;
      @(negedge clk);
    end
    tests_run++;
    if (cyc_seen) begin
      tests_failed++; $display("FAIL zero_len_idle: cyc/busy rose=%b, required 0", cyc_seen);
    end
  endtask

  task automatic test_abort();
    start_i = 1'b1; addr_i = 24'h000300; len_i = 16'd8; ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    tests_run++;
    if (wb_cyc_o !== 1'b1 || wb_adr_o !== 24'h000300) begin
      tests_failed++; $display("FAIL abort_start: cyc=%b adr=%h, required 1 000300", wb_cyc_o, wb_adr_o);
    end
    wb_ack_i = 1'b1; wb_dat_i = sram(wb_adr_o);
    @(negedge clk);
    wb_dat_i = sram(wb_adr_o);
    @(negedge clk);
    wb_ack_i = 1'b0; ready_i = 1'b1;
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== sram(24'h000300)) begin
      tests_failed++; $display("FAIL abort_head: valid=%b data=%h, required 1 %h", valid_o, data_o, sram(24'h000300));
    end
    @(negedge clk);
    ready_i = 1'b0;
    abort_i = 1'b1; wb_ack_i = wb_cyc_o; wb_dat_i = sram(wb_adr_o);
    @(negedge clk);
    abort_i = 1'b0; wb_ack_i = 1'b0;
    tests_run++;
    if (wb_cyc_o !== 1'b0 || valid_o !== 1'b0 || done_o !== 1'b1 || busy_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort: cyc=%b valid=%b done=%b busy=%b, required 0 0 1 0", wb_cyc_o, valid_o, done_o, busy_o);
    end
    @(negedge clk);
    tests_run++;
    if (done_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
      tests_failed++; $display("FAIL abort_after: done=%b cyc=%b, required 0 0", done_o, wb_cyc_o);
    end
    run_xfer(24'h000200, 5, 1, 1'b0, "post_abort");
  endtask

  task automatic test_reset_mid_burst();
    start_i = 1'b1; addr_i = 24'h000400; len_i = 16'd10; ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = sram(wb_adr_o);
    @(negedge clk);
    wb_dat_i = sram(wb_adr_o);
    @(negedge clk);
    wb_ack_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    tests_run++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy_o !== 1'b0 || valid_o !== 1'b0 || wb_adr_o !== 24'h0) begin
      tests_failed++; $display("FAIL async_reset: cyc=%b stb=%b busy=%b valid=%b adr=%h, required 0 0 0 0 000000",
                               wb_cyc_o, wb_stb_o, busy_o, valid_o, wb_adr_o);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    run_xfer(24'h000500, 9, 1, 1'b1, "held_start");
  endtask

  task automatic test_random();
    logic [23:0] a;
    for (int k = 0; k < 6; k++) begin
      a = 24'($urandom);
      run_xfer(a, $urandom_range(1, 24), $urandom_range(0, 2), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    run_xfer(24'h000100, 3, 0, 1'b0, "single_burst");
    run_xfer(24'h000100, 10, 2, 1'b0, "backpressure");
    run_xfer(24'hFFFFFE, 4, 1, 1'b0, "addr_wrap");
    test_zero_len();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_sram_burst_reader
